button_event: RTL

//  Consumer side of the debounced push-button path. Takes the clean pbreg level from

---
 rtl/button_event.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/button_event.sv
// Turns the debounced push-button level into press/release/auto-repeat pulses in the clk domain.
// Latency: pulses register on the 3rd clk edge after pb_level_i changes; there is no backpressure.
module button_event #(
  parameter int unsigned CLK_HZ          = 100_000_000,
  parameter int unsigned REPEAT_DELAY_MS = 400,
  parameter int unsigned REPEAT_RATE_MS  = 100,
  parameter int unsigned HOLD_W          = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pb_level_i,
  output logic              press_o,
  output logic              release_o,
  output logic              rpt_o,
  output logic              held_o,
  output logic [HOLD_W-1:0] hold_ms_o
);

  localparam int unsigned TICK_DIV = CLK_HZ / 1000;
  localparam int unsigned PS_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned MS_MAX   = (REPEAT_DELAY_MS > REPEAT_RATE_MS) ? REPEAT_DELAY_MS
                                                                        : REPEAT_RATE_MS;
  localparam int unsigned MS_W     = (MS_MAX > 1) ? $clog2(MS_MAX + 1) : 1;
  localparam bit          RPT_EN   = (REPEAT_DELAY_MS != 0);

  localparam logic [PS_W-1:0] PS_LAST   = PS_W'(TICK_DIV - 1);
  localparam logic [MS_W-1:0] DELAY_CNT = MS_W'(REPEAT_DELAY_MS);
  localparam logic [MS_W-1:0] RATE_CNT  = MS_W'(REPEAT_RATE_MS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } state_e;

  logic              s1_q, s2_q, s3_q;
  logic              rise, fall;
  state_e            state_q, state_d;
  logic [PS_W-1:0]   ps_q, ps_d;
  logic [MS_W-1:0]   ms_q, ms_d, ms_inc;
  logic [HOLD_W-1:0] hold_q, hold_d, hold_inc;
  logic              press_q, press_d;
  logic              release_q, release_d;
  logic              rpt_q, rpt_d;
  logic              held_q, held_d;
  logic              tick;

  // s1/s2 resolve metastability; s3 holds the previous synchronised level for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= pb_level_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rise     = s2_q & ~s3_q;
  assign fall     = ~s2_q & s3_q;
  assign tick     = (ps_q == PS_LAST);
  assign ms_inc   = ms_q + 1'b1;
  assign hold_inc = (hold_q == {HOLD_W{1'b1}}) ? hold_q : hold_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    ps_d      = ps_q;
    ms_d      = ms_q;
    hold_d    = hold_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    rpt_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise) begin
          press_d = 1'b1;
          ps_d    = '0;
          ms_d    = '0;
          hold_d  = '0;
          state_d = DELAY;
        end
      end
      DELAY, REPEAT: begin
        // A fall wins over any tick or repeat due in the same cycle; hold_ms stays frozen.
        if (fall) begin
          release_d = 1'b1;
          ps_d      = '0;
          ms_d      = '0;
          state_d   = IDLE;
        end else begin
          ps_d = tick ? '0 : ps_q + 1'b1;
          if (tick) begin
            hold_d = hold_inc;
            if (state_q == DELAY) begin
              if (RPT_EN) begin
                if (ms_inc == DELAY_CNT) begin
                  rpt_d   = 1'b1;
                  ms_d    = '0;
                  state_d = REPEAT;
                end else begin
                  ms_d = ms_inc;
                end
              end
            end else begin
              if (ms_inc == RATE_CNT) begin
                rpt_d = 1'b1;
                ms_d  = '0;
              end else begin
                ms_d = ms_inc;
              end
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    held_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ps_q      <= '0;
      ms_q      <= '0;
      hold_q    <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      rpt_q     <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ps_q      <= ps_d;
      ms_q      <= ms_d;
      hold_q    <= hold_d;
      press_q   <= press_d;
      release_q <= release_d;
      rpt_q     <= rpt_d;
      held_q    <= held_d;
    end
  end

  assign press_o   = press_q;
  assign release_o = release_q;
  assign rpt_o     = rpt_q;
  assign held_o    = held_q;
  assign hold_ms_o = hold_q;

endmodule
